// File: rtl/sram_pkg.sv
// Shared definitions for the 1W/1R SRAM and its neighbours (the AHB
// controller reuses merge_be for HSIZE byte-lane generation).
package sram_pkg;

  localparam int LANE_W = 8;

  // merge_be works on a fixed maximum width so any caller can use it:
  // zero-extend the operands and keep the low bits of the result.
  localparam int MERGE_MAX_NB = 64;
  localparam int MERGE_MAX_W  = MERGE_MAX_NB * LANE_W;

  // Per-lane mux: lane i comes from new_word when be[i] is set, else old_word.
  function automatic logic [MERGE_MAX_W-1:0] merge_be(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_NB-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_MAX_NB; i++) begin
      if (be[i]) res[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result pipeline: valid, data and collision travel together through
// 1 + OUT_REG stages. Data registers only load when their valid input is set,
// so the output holds its last value between reads.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  coll_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  coll_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int STAGES = 1 + OUT_REG;

  logic [STAGES-1:0]                 valid_q, valid_d;
  logic [STAGES-1:0]                 coll_q, coll_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q, data_d;

  // Next-state: shift valid/collision, load data only behind a valid.
  always_comb begin
    valid_d   = valid_q;
    coll_d    = coll_q;
    data_d    = data_q;
    valid_d[0] = valid_i;
    coll_d[0]  = valid_i & coll_i;
    if (valid_i) data_d[0] = data_i;
    for (int s = 1; s < STAGES; s++) begin
      valid_d[s] = valid_q[s-1];
      coll_d[s]  = coll_q[s-1];
      if (valid_q[s-1]) data_d[s] = data_q[s-1];
    end
  end

  // Stage registers; reset drops every in-flight read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      coll_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      coll_q  <= coll_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign coll_o  = coll_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/sram_1w1r_be.sv
// Single-clock 1W/1R SRAM with byte enables, 1- or 2-cycle read latency,
// deterministic read-during-write (bypass or old data) and a collision flag.
module sram_1w1r_be
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int OUT_REG    = 0,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH/LANE_W-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         collision
);

  localparam int NB    = DATA_WIDTH / LANE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  if (DATA_WIDTH % LANE_W != 0) begin : g_bad_width
    $error("sram_1w1r_be: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("sram_1w1r_be: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (DATA_WIDTH > MERGE_MAX_W) begin : g_too_wide
    $error("sram_1w1r_be: DATA_WIDTH exceeds merge_be maximum width");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_outreg
    $error("sram_1w1r_be: OUT_REG must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_in_range, rd_in_range, wr_fire, same_addr;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;
  logic [MERGE_MAX_W-1:0] wr_merge_w, rd_merge_w;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_fire     = !rst && wr_en && wr_in_range && (|wr_be);

  // Collision only counts for a real (non-empty) in-range write to the read address.
  assign same_addr = wr_en && rd_en && wr_in_range && rd_in_range &&
                     (wr_addr == rd_addr) && (|wr_be);

  assign rd_old = rd_in_range ? mem_q[rd_idx] : '0;

  assign wr_merge_w = merge_be(MERGE_MAX_W'(mem_q[wr_idx]), MERGE_MAX_W'(wr_data),
                               MERGE_MAX_NB'(wr_be));
  assign rd_merge_w = merge_be(MERGE_MAX_W'(rd_old), MERGE_MAX_W'(wr_data),
                               MERGE_MAX_NB'(wr_be));

  if (DATA_WIDTH < MERGE_MAX_W) begin : g_merge_hi
    logic unused_merge_hi;
    assign unused_merge_hi = ^{wr_merge_w[MERGE_MAX_W-1:DATA_WIDTH],
                               rd_merge_w[MERGE_MAX_W-1:DATA_WIDTH]};
  end

  // Same-address read-during-write sees the merged word only in bypass mode;
  // otherwise the array read is naturally the pre-write contents.
  assign rd_word = ((BYPASS != 0) && same_addr) ? rd_merge_w[DATA_WIDTH-1:0] : rd_old;

  // Array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_idx] <= wr_merge_w[DATA_WIDTH-1:0];
  end

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rd_pipe (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (rd_en && !rst),
    .coll_i  (same_addr),
    .data_i  (rd_word),
    .valid_o (rd_valid),
    .coll_o  (collision),
    .data_o  (rd_data)
  );

endmodule

// File: tb/tb_sram_1w1r_be.sv
// Directed bench: two instances share stimulus.
//   dut_a: DEPTH=200, OUT_REG=0, BYPASS=1
//   dut_b: DEPTH=256, OUT_REG=1, BYPASS=0
module tb_sram_1w1r_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid, a_coll, b_coll;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_1w1r_be #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .OUT_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .collision(a_coll));

  sram_1w1r_be #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .OUT_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .collision(b_coll));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  // One read (optionally with a simultaneous write), checked on both instances.
  task automatic rw(input string tag, input logic we, input logic [7:0] wa, input logic [3:0] be,
                    input logic [31:0] wd, input logic [7:0] ra,
                    input logic [31:0] ea, input logic ca, input logic [31:0] eb, input logic cb);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = 1'b1; rd_addr = ra;
    step();
    chk({tag, "/a_valid"}, 32'(a_rd_valid), 32'd1);
    chk({tag, "/a_data"},  a_rd_data, ea);
    chk({tag, "/a_coll"},  32'(a_coll), 32'(ca));
    chk({tag, "/b_early"}, 32'(b_rd_valid), 32'd0);
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk({tag, "/a_drop"},  32'(a_rd_valid), 32'd0);
    chk({tag, "/a_hold"},  a_rd_data, ea);
    chk({tag, "/a_coll0"}, 32'(a_coll), 32'd0);
    chk({tag, "/b_valid"}, 32'(b_rd_valid), 32'd1);
    chk({tag, "/b_data"},  b_rd_data, eb);
    chk({tag, "/b_coll"},  32'(b_coll), 32'(cb));
    step();
    chk({tag, "/b_drop"},  32'(b_rd_valid), 32'd0);
    chk({tag, "/b_hold"},  b_rd_data, eb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b1; rd_addr = 8'h05;

    // Reads requested during reset never come out.
    repeat (3) step();
    chk("rst/a_valid", 32'(a_rd_valid), 32'd0);
    chk("rst/a_data",  a_rd_data, 32'd0);
    chk("rst/b_valid", 32'(b_rd_valid), 32'd0);
    chk("rst/b_data",  b_rd_data, 32'd0);
    rst = 1'b0; rd_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst/a_valid", 32'(a_rd_valid), 32'd0);
      chk("post_rst/a_data",  a_rd_data, 32'd0);
      chk("post_rst/b_valid", 32'(b_rd_valid), 32'd0);
      chk("post_rst/b_data",  b_rd_data, 32'd0);
    end

    // Full-word write then read.
    write(8'h10, 4'hF, 32'hDEADBEEF);
    rw("full", 1'b0, 8'h00, 4'h0, 32'h0, 8'h10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);

    // Partial-lane write.
    write(8'h10, 4'b0101, 32'h11223344);
    rw("lanes", 1'b0, 8'h00, 4'h0, 32'h0, 8'h10, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);

    // Read-during-write on the same address.
    write(8'h20, 4'hF, 32'h00000000);
    rw("coll", 1'b1, 8'h20, 4'b1100, 32'hAABBCCDD, 8'h20, 32'hAABB0000, 1'b1, 32'h00000000, 1'b1);
    rw("after_coll", 1'b0, 8'h00, 4'h0, 32'h0, 8'h20, 32'hAABB0000, 1'b0, 32'hAABB0000, 1'b0);
    rw("be0_nocoll", 1'b1, 8'h20, 4'h0, 32'hFFFFFFFF, 8'h20, 32'hAABB0000, 1'b0, 32'hAABB0000, 1'b0);
    rw("diff_addr", 1'b1, 8'h21, 4'hF, 32'h12345678, 8'h20, 32'hAABB0000, 1'b0, 32'hAABB0000, 1'b0);
    rw("diff_rd", 1'b0, 8'h00, 4'h0, 32'h0, 8'h21, 32'h12345678, 1'b0, 32'h12345678, 1'b0);

    // Depth boundary: 250 and 200 are out of range for dut_a only.
    write(8'd250, 4'hF, 32'h5A5A5A5A);
    rw("oor_rd", 1'b0, 8'h00, 4'h0, 32'h0, 8'd250, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b0);
    rw("oor_coll", 1'b1, 8'd250, 4'hF, 32'h0F0F0F0F, 8'd250, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b1);
    write(8'd200, 4'hF, 32'h0000C8C8);
    rw("edge200", 1'b0, 8'h00, 4'h0, 32'h0, 8'd200, 32'h0, 1'b0, 32'h0000C8C8, 1'b0);
    write(8'd199, 4'hF, 32'h01990199);
    rw("edge199", 1'b0, 8'h00, 4'h0, 32'h0, 8'd199, 32'h01990199, 1'b0, 32'h01990199, 1'b0);

    // Streaming with a one-cycle reset after the 8th request.
    for (int i = 0; i < 16; i++) write(8'(i), 4'hF, 32'(i));
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr = 8'(i);
      step();
      chk("strm1/a_valid", 32'(a_rd_valid), 32'd1);
      chk("strm1/a_data",  a_rd_data, 32'(i));
      if (i == 0) chk("strm1/b_valid0", 32'(b_rd_valid), 32'd0);
      else begin
        chk("strm1/b_valid", 32'(b_rd_valid), 32'd1);
        chk("strm1/b_data",  b_rd_data, 32'(i - 1));
      end
    end
    rst = 1'b1; rd_en = 1'b1; rd_addr = 8'd8;
    step();
    chk("strm_rst/a_valid", 32'(a_rd_valid), 32'd0);
    chk("strm_rst/a_data",  a_rd_data, 32'd0);
    chk("strm_rst/b_valid", 32'(b_rd_valid), 32'd0);
    chk("strm_rst/b_data",  b_rd_data, 32'd0);
    rst = 1'b0;
    for (int i = 8; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 8'(i);
      step();
      chk("strm2/a_valid", 32'(a_rd_valid), 32'd1);
      chk("strm2/a_data",  a_rd_data, 32'(i));
      if (i == 8) begin
        chk("strm2/b_dropped", 32'(b_rd_valid), 32'd0);
        chk("strm2/b_data0",   b_rd_data, 32'd0);
      end else begin
        chk("strm2/b_valid", 32'(b_rd_valid), 32'd1);
        chk("strm2/b_data",  b_rd_data, 32'(i - 1));
      end
    end
    rd_en = 1'b0;
    step();
    chk("strm_end/a_valid", 32'(a_rd_valid), 32'd0);
    chk("strm_end/a_hold",  a_rd_data, 32'd15);
    chk("strm_end/b_valid", 32'(b_rd_valid), 32'd1);
    chk("strm_end/b_data",  b_rd_data, 32'd15);
    step();
    chk("strm_end/b_drop", 32'(b_rd_valid), 32'd0);
    chk("strm_end/b_hold", b_rd_data, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
